// File: rtl/fuzz_top_pkg.sv
// fuzz_top_pkg
// Shared constants for the fuzz_top mixing datapath: operand widths, the
// layout of the 245-bit status word (field widths and LSB offsets), the
// signed 22-bit saturation bounds and a popcount helper.
// Build option: FUZZ_TOP_SAT_EN (consumed by fuzz_top_sat_add).
package fuzz_top_pkg;

    // Operand widths
    localparam int A_W = 17;   // wire0, unsigned
    localparam int B_W = 11;   // wire1, signed
    localparam int C_W = 12;   // wire2, unsigned
    localparam int D_W = 21;   // wire3, unsigned
    localparam int E_W = 22;   // wire4, signed

    localparam int Y_W = 245;

    // Field widths
    localparam int IN_W   = A_W + B_W + C_W + D_W + E_W;  // 83
    localparam int PROD_W = 34;
    localparam int ACC_W  = 32;
    localparam int ROT_W  = 32;
    localparam int SUM_W  = 22;
    localparam int MAX_W  = 21;
    localparam int POP_W  = 5;
    localparam int CNT_W  = 16;

    // Field LSB offsets inside y
    localparam int IN_LSB   = 162;
    localparam int PROD_LSB = 128;
    localparam int ACC_LSB  = 96;
    localparam int ROT_LSB  = 64;
    localparam int SUM_LSB  = 42;
    localparam int MAX_LSB  = 21;
    localparam int POP_LSB  = 16;
    localparam int CNT_LSB  = 0;

    // Signed 22-bit saturation bounds
    localparam logic signed [SUM_W-1:0] SUM_MAX = 22'sh1FFFFF;
    localparam logic signed [SUM_W-1:0] SUM_MIN = 22'sh200000;

    // Number of set bits in a 17-bit operand (0..17 fits in 5 bits)
    function automatic logic [POP_W-1:0] popcount_a(input logic [A_W-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < A_W; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/fuzz_top_sat_add.sv
// fuzz_top_sat_add
// Combinational signed adder: sum = e + sign_ext(b), 22-bit result.
// Ports:
//   e   in  22  signed operand
//   b   in  11  signed operand, sign-extended before the add
//   sum out 22  reduced result
// Build option: FUZZ_TOP_SAT_EN defined -> the 23-bit sum saturates to the
// signed 22-bit range; undefined -> two's-complement wrap to 22 bits.
module fuzz_top_sat_add
    import fuzz_top_pkg::*;
(
    input  logic signed [E_W-1:0]   e,
    input  logic signed [B_W-1:0]   b,
    output logic signed [SUM_W-1:0] sum
);

`ifdef FUZZ_TOP_SAT_EN
    // Clamp a 23-bit signed value into 22 bits. The top two bits disagree
    // exactly when the value falls outside the 22-bit signed range.
    function automatic logic signed [SUM_W-1:0] sat22(input logic signed [SUM_W:0] v);
        if (!v[SUM_W] && v[SUM_W-1]) begin
            return SUM_MAX;
        end else if (v[SUM_W] && !v[SUM_W-1]) begin
            return SUM_MIN;
        end else begin
            return v[SUM_W-1:0];
        end
    endfunction

    logic signed [SUM_W:0] wide;

    assign wide = {e[E_W-1], e} + {{(SUM_W + 1 - B_W){b[B_W-1]}}, b};
    assign sum  = sat22(wide);
`else
    // The low 22 bits of the 23-bit sum equal a plain 22-bit add.
    assign sum = e + {{(SUM_W - B_W){b[B_W-1]}}, b};
`endif

endmodule

// File: rtl/fuzz_top.sv
// fuzz_top
// Registered mixing datapath. Every rising edge samples five operands and
// updates capture, product, accumulator, rotate-xor, sum, running max,
// popcount and cycle-count registers, exposed together on y (MSB first):
//   [244:162] in   [161:128] prod  [127:96] acc  [95:64] rot
//   [63:42]   sum  [41:21]   max   [20:16]  pop  [15:0]  cnt
// Ports:
//   clk    in   1   rising-edge clock
//   rst    in   1   asynchronous active-high reset, clears every field
//   wire0  in  17   unsigned operand A
//   wire1  in  11   signed operand B
//   wire2  in  12   unsigned operand C (captured only)
//   wire3  in  21   unsigned operand D
//   wire4  in  22   signed operand E
//   y      out 245  status word, all fields registered
// Build option: FUZZ_TOP_SAT_EN selects saturating sum (see fuzz_top_sat_add).
module fuzz_top
    import fuzz_top_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic        [A_W-1:0] wire0,
    input  logic signed [B_W-1:0] wire1,
    input  logic        [C_W-1:0] wire2,
    input  logic        [D_W-1:0] wire3,
    input  logic signed [E_W-1:0] wire4,
    output logic        [Y_W-1:0] y
);

    logic        [IN_W-1:0]   in_p1;
    logic signed [PROD_W-1:0] prod_p1;
    logic        [ACC_W-1:0]  acc_p1;
    logic        [ROT_W-1:0]  rot_p1;
    logic signed [SUM_W-1:0]  sum_p1;
    logic        [MAX_W-1:0]  max_p1;
    logic        [POP_W-1:0]  pop_p1;
    logic        [CNT_W-1:0]  cnt_p1;

    logic signed [PROD_W-1:0] prod_p0;
    logic signed [SUM_W-1:0]  sum_p0;

    // Both operands widened to 34 bits so the product is sign-extended.
    assign prod_p0 = $signed({{(PROD_W - B_W){wire1[B_W-1]}}, wire1})
                   * $signed({{(PROD_W - E_W){wire4[E_W-1]}}, wire4});

    fuzz_top_sat_add u_sat_add (
        .e   (wire4),
        .b   (wire1),
        .sum (sum_p0)
    );

    // ---- stage p0 -> p1: single register stage for every field ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_p1   <= '0;
            prod_p1 <= '0;
            acc_p1  <= '0;
            rot_p1  <= '0;
            sum_p1  <= '0;
            max_p1  <= '0;
            pop_p1  <= '0;
            cnt_p1  <= '0;
        end else begin
            in_p1   <= {wire0, wire1, wire2, wire3, wire4};
            prod_p1 <= prod_p0;
            acc_p1  <= acc_p1 + {{(ACC_W - A_W){1'b0}}, wire0};
            rot_p1  <= {rot_p1[ROT_W-2:0], rot_p1[ROT_W-1]}
                       ^ {{(ROT_W - D_W){1'b0}}, wire3};
            sum_p1  <= sum_p0;
            // Strictly greater: ties keep the stored value.
            if (wire3 > max_p1) begin
                max_p1 <= wire3;
            end
            pop_p1  <= popcount_a(wire0);
            cnt_p1  <= cnt_p1 + 16'd1;
        end
    end

    assign y = {in_p1, prod_p1, acc_p1, rot_p1, sum_p1, max_p1, pop_p1, cnt_p1};

endmodule

// File: tb/tb_fuzz_top.sv
// tb_fuzz_top
// Directed self-checking bench for fuzz_top. Expected values are constants
// worked out by hand; the saturation expectations follow FUZZ_TOP_SAT_EN.
module tb_fuzz_top;
    import fuzz_top_pkg::*;

    logic                  clk;
    logic                  rst;
    logic        [A_W-1:0] wire0;
    logic signed [B_W-1:0] wire1;
    logic        [C_W-1:0] wire2;
    logic        [D_W-1:0] wire3;
    logic signed [E_W-1:0] wire4;
    logic        [Y_W-1:0] y;

    int checks;
    int errors;
    int edges;

    fuzz_top dut (
        .clk   (clk),
        .rst   (rst),
        .wire0 (wire0),
        .wire1 (wire1),
        .wire2 (wire2),
        .wire3 (wire3),
        .wire4 (wire4),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    logic [IN_W-1:0]  exp_in;
    logic [SUM_W-1:0] exp_sat_hi;
    logic [SUM_W-1:0] exp_sat_lo;

    initial begin
        checks = 0;
        errors = 0;
        edges  = 0;
        rst    = 1'b1;
        wire0  = '0;
        wire1  = '0;
        wire2  = '0;
        wire3  = '0;
        wire4  = '0;

        // 1. Reset held with random inputs and running clock
        for (int i = 0; i < 3; i++) begin
            wire0 = A_W'($urandom);
            wire1 = B_W'($urandom);
            wire2 = C_W'($urandom);
            wire3 = D_W'($urandom);
            wire4 = E_W'($urandom);
            step();
            chk("reset_hold_y", y, '0);
        end

        // 2. Single sample after reset
        rst   = 1'b0;
        edges = 0;
        wire0 = 17'h1FFFF;
        wire1 = 11'h7FF;
        wire2 = 12'hABC;
        wire3 = 21'h000005;
        wire4 = 22'h000005;
        exp_in = {17'h1FFFF, 11'h7FF, 12'hABC, 21'h000005, 22'h000005};
        step();
        chk("first_in",   y[IN_LSB   +: IN_W],   exp_in);
        chk("first_prod", y[PROD_LSB +: PROD_W], 34'h3FFFFFFFB);
        chk("first_sum",  y[SUM_LSB  +: SUM_W],  22'h000004);
        chk("first_acc",  y[ACC_LSB  +: ACC_W],  32'h0001FFFF);
        chk("first_rot",  y[ROT_LSB  +: ROT_W],  32'h00000005);
        chk("first_max",  y[MAX_LSB  +: MAX_W],  21'd5);
        chk("first_pop",  y[POP_LSB  +: POP_W],  5'd17);
        chk("first_cnt",  y[CNT_LSB  +: CNT_W],  16'd1);

        // 3. Sum overflow in both directions
`ifdef FUZZ_TOP_SAT_EN
        exp_sat_hi = 22'h1FFFFF;
        exp_sat_lo = 22'h200000;
`else
        exp_sat_hi = 22'h200000;
        exp_sat_lo = 22'h1FFFFF;
`endif
        wire4 = 22'h1FFFFF;
        wire1 = 11'd1;
        step();
        chk("sum_pos_ovf", y[SUM_LSB +: SUM_W], exp_sat_hi);
        chk("prod_pos", y[PROD_LSB +: PROD_W], 34'h0001FFFFF);
        wire4 = 22'h200000;
        wire1 = 11'h7FF;
        step();
        chk("sum_neg_ovf", y[SUM_LSB +: SUM_W], exp_sat_lo);
        chk("prod_neg_neg", y[PROD_LSB +: PROD_W], 34'h000200000);
        chk("cnt_three", y[CNT_LSB +: CNT_W], 16'd3);

        // 5. Running max (starts from 5), popcount on a sparse pattern
        wire0 = 17'h000A5;
        wire3 = 21'd10;
        step();
        chk("max_10", y[MAX_LSB +: MAX_W], 21'd10);
        chk("pop_a5", y[POP_LSB +: POP_W], 5'd4);
        wire3 = 21'd3;
        step();
        chk("max_keep", y[MAX_LSB +: MAX_W], 21'd10);
        wire3 = 21'h1FFFFF;
        step();
        chk("max_top", y[MAX_LSB +: MAX_W], 21'h1FFFFF);
        wire3 = 21'd7;
        step();
        chk("max_hold_top", y[MAX_LSB +: MAX_W], 21'h1FFFFF);

        // 4. Fresh reset, then rotate walk and accumulator wrap
        rst = 1'b1;
        step();
        chk("reset_again_y", y, '0);
        rst   = 1'b0;
        edges = 0;
        wire0 = '0;
        wire1 = '0;
        wire2 = '0;
        wire4 = '0;
        wire3 = 21'd1;
        step();
        chk("rot_seed", y[ROT_LSB +: ROT_W], 32'h00000001);
        wire3 = '0;
        for (int i = 0; i < 31; i++) step();
        chk("rot_msb", y[ROT_LSB +: ROT_W], 32'h80000000);
        step();
        chk("rot_wrap", y[ROT_LSB +: ROT_W], 32'h00000001);
        chk("acc_zero", y[ACC_LSB +: ACC_W], 32'h0);

        wire0 = 17'h1FFFF;
        for (int i = 0; i < 32769; i++) step();
        chk("acc_wrap", y[ACC_LSB +: ACC_W], 32'h00017FFF);
        chk("cnt_mid", y[CNT_LSB +: CNT_W], 16'h8022);

        // 6. Counter wrap
        wire0 = '0;
        while (edges < 65535) step();
        chk("cnt_ffff", y[CNT_LSB +: CNT_W], 16'hFFFF);
        step();
        chk("cnt_wrap", y[CNT_LSB +: CNT_W], 16'h0000);
        step();
        chk("cnt_after_wrap", y[CNT_LSB +: CNT_W], 16'h0001);

        // Asynchronous reset between edges
        wire0 = 17'h00003;
        wire3 = 21'd9;
        step();
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset_y", y, '0);
        step();
        chk("async_hold_y", y, '0);
        rst   = 1'b0;
        edges = 0;
        wire3 = 21'd7;
        step();
        chk("post_rst_cnt", y[CNT_LSB +: CNT_W], 16'd1);
        chk("post_rst_acc", y[ACC_LSB +: ACC_W], 32'd3);
        chk("post_rst_rot", y[ROT_LSB +: ROT_W], 32'd7);
        chk("post_rst_max", y[MAX_LSB +: MAX_W], 21'd7);
        chk("post_rst_pop", y[POP_LSB +: POP_W], 5'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
